// File: rtl/riscv_lsu_if.sv
// riscv_lsu_if: core-side and memory-side signal bundle of the load-store unit
// Ports (slave = LSU view):
//   core_req_i/core_we_i/core_size_i/core_addr_i/core_wd_i  in   core request
//   core_rd_o/core_stall_o                                  out  load data, stall
//   mem_req_o/mem_we_o/mem_be_o/mem_addr_o/mem_wd_o         out  memory request
//   mem_rd_i/mem_ready_i                                    in   memory response
// The master modport is the core plus memory seen from outside the LSU.
interface riscv_lsu_if;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;
  modport slave (
    input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i, mem_rd_i, mem_ready_i,
    output core_rd_o, core_stall_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
  );
  modport master (
    output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i, mem_rd_i, mem_ready_i,
    input  core_rd_o, core_stall_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
  );
endinterface

// File: rtl/riscv_lsu.sv
// riscv_lsu: load-store unit between the RISC-V core and word-wide data memory
// Ports:
//   clk_i  in  clock
//   rst_i  in  asynchronous active-high reset
//   bus    riscv_lsu_if.slave  core request/stall/load data and memory request/response
module riscv_lsu (
  input  logic        clk_i,
  input  logic        rst_i,
  riscv_lsu_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t      r_state, w_next;
  logic [2:0]  r_size;
  logic [1:0]  r_off;
  logic        r_mem_req, r_mem_we;
  logic [3:0]  r_mem_be;
  logic [31:0] r_mem_addr, r_mem_wd, r_rd;
  logic        w_stall, w_b, w_h, w_sx;
  logic [3:0]  w_be;
  logic [31:0] w_wd, w_fmt;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  // size[1:0] picks the width (0 byte, 1 half, else word); size[2] marks unsigned loads
  assign w_b  = bus.core_size_i[1:0] == 2'b00;
  assign w_h  = bus.core_size_i[1:0] == 2'b01;
  assign w_be = w_b ? 4'b0001 << bus.core_addr_i[1:0]
              : w_h ? (bus.core_addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign w_wd = w_b ? {4{bus.core_wd_i[7:0]}} : w_h ? {2{bus.core_wd_i[15:0]}} : bus.core_wd_i;
  assign w_sx   = ~r_size[2];
  assign w_byte = bus.mem_rd_i[{r_off, 3'b000} +: 8];
  assign w_half = r_off[1] ? bus.mem_rd_i[31:16] : bus.mem_rd_i[15:0];
  assign w_fmt  = r_size[1:0] == 2'b00 ? {{24{w_sx & w_byte[7]}}, w_byte}
                : r_size[1:0] == 2'b01 ? {{16{w_sx & w_half[15]}}, w_half} : bus.mem_rd_i;
  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    case (r_state)
      IDLE: begin
        w_stall = bus.core_req_i;
        w_next  = bus.core_req_i ? REQ : IDLE;
      end
      REQ: begin
        w_stall = 1'b1;
        w_next  = bus.mem_ready_i ? DONE : REQ;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_size     <= '0;
      r_off      <= '0;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_be   <= '0;
      r_mem_addr <= '0;
      r_mem_wd   <= '0;
      r_rd       <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && bus.core_req_i) begin
        r_mem_req  <= 1'b1;
        r_mem_we   <= bus.core_we_i;
        r_mem_be   <= w_be;
        r_mem_addr <= {bus.core_addr_i[31:2], 2'b00};
        r_mem_wd   <= w_wd;
        r_size     <= bus.core_size_i;
        r_off      <= bus.core_addr_i[1:0];
      end else if (r_state == REQ && bus.mem_ready_i) begin
        r_mem_req <= 1'b0;
        r_mem_we  <= 1'b0;
        r_mem_be  <= '0;
        // r_mem_we still holds the captured direction here
        if (!r_mem_we) r_rd <= w_fmt;
      end
    end
  end
  assign bus.core_stall_o = w_stall;
  assign bus.core_rd_o    = r_rd;
  assign bus.mem_req_o    = r_mem_req;
  assign bus.mem_we_o     = r_mem_we;
  assign bus.mem_be_o     = r_mem_be;
  assign bus.mem_addr_o   = r_mem_addr;
  assign bus.mem_wd_o     = r_mem_wd;
endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: directed and random load/store transactions against a byte-lane model
module tb_riscv_lsu;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  riscv_lsu_if bus();
  riscv_lsu dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_rd = '0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic int nbytes(input logic [2:0] sz);
    case (sz)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction
  function automatic logic [3:0] m_be(input logic [2:0] sz, input logic [31:0] a);
    int n = nbytes(sz);
    int s = (int'(a[1:0]) / n) * n;
    logic [3:0] r = '0;
    for (int i = 0; i < 4; i++) r[i] = (i >= s) && (i < s + n);
    return r;
  endfunction
  function automatic logic [31:0] m_wd(input logic [2:0] sz, input logic [31:0] wd);
    int n = nbytes(sz);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction
  function automatic logic [31:0] m_load(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] w);
    int n = nbytes(sz);
    int s = (int'(a[1:0]) / n) * n;
    logic [31:0] v = w >> (8 * s);
    if (n == 4) return w;
    v = (n == 1) ? (v & 32'hFF) : (v & 32'hFFFF);
    if ((sz == 3'd0 || sz == 3'd1) && v[8*n-1]) v = v | ((n == 1) ? 32'hFFFF_FF00 : 32'hFFFF_0000);
    return v;
  endfunction
  task automatic do_txn(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] word, input int waits);
    logic [3:0]  be  = m_be(sz, addr);
    logic [31:0] wdx = m_wd(sz, wd);
    int stalls = 0;
    bus.core_req_i  = 1'b1;
    bus.core_we_i   = we;
    bus.core_size_i = sz;
    bus.core_addr_i = addr;
    bus.core_wd_i   = wd;
    bus.mem_ready_i = 1'b0;
    bus.mem_rd_i    = $urandom;
    #1;
    check("stall_idle", bus.core_stall_o, 1);
    stalls += int'(bus.core_stall_o);
    step();
    for (int k = 0; k <= waits; k++) begin
      check("req_mem_req", bus.mem_req_o, 1);
      check("req_mem_we", bus.mem_we_o, we);
      check("req_mem_be", bus.mem_be_o, be);
      check("req_mem_addr", bus.mem_addr_o, {addr[31:2], 2'b00});
      check("req_mem_wd", bus.mem_wd_o, wdx);
      stalls += int'(bus.core_stall_o);
      if (k < waits) begin
        bus.core_addr_i = $urandom;
        bus.core_wd_i   = $urandom;
        bus.core_size_i = 3'($urandom);
        bus.core_we_i   = 1'($urandom);
        bus.mem_rd_i    = $urandom;
        step();
      end
    end
    bus.mem_ready_i = 1'b1;
    bus.mem_rd_i    = word;
    step();
    if (!we) exp_rd = m_load(sz, addr, word);
    bus.mem_ready_i = 1'($urandom);
    check("done_stall", bus.core_stall_o, 0);
    check("done_mem_req", bus.mem_req_o, 0);
    check("done_mem_we", bus.mem_we_o, 0);
    check("done_mem_be", bus.mem_be_o, 0);
    check("done_rd", bus.core_rd_o, exp_rd);
    check("stall_cycles", 32'(stalls), 32'(waits + 2));
    step();
    bus.core_req_i  = 1'b0;
    bus.mem_ready_i = 1'($urandom);
    #1;
    check("idle_stall", bus.core_stall_o, 0);
    check("idle_mem_req", bus.mem_req_o, 0);
    step();
    bus.mem_ready_i = 1'b0;
    check("idle2_mem_req", bus.mem_req_o, 0);
    check("idle2_rd", bus.core_rd_o, exp_rd);
  endtask
  initial begin
    bus.core_req_i  = 1'b0;
    bus.core_we_i   = 1'b0;
    bus.core_size_i = '0;
    bus.core_addr_i = '0;
    bus.core_wd_i   = '0;
    bus.mem_rd_i    = '0;
    bus.mem_ready_i = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_mem_req", bus.mem_req_o, 0);
    check("rst_mem_be", bus.mem_be_o, 0);
    check("rst_mem_addr", bus.mem_addr_o, 0);
    check("rst_mem_wd", bus.mem_wd_o, 0);
    check("rst_rd", bus.core_rd_o, 0);
    check("rst_stall", bus.core_stall_o, 0);
    step();
    rst = 1'b0;
    step();
    do_txn(1'b0, 3'd2, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 0);
    check("lw_const", bus.core_rd_o, 32'hDEAD_BEEF);
    do_txn(1'b0, 3'd0, 32'h0000_2003, 32'h0, 32'h80FF_0011, 0);
    check("lb_const", bus.core_rd_o, 32'hFFFF_FF80);
    do_txn(1'b0, 3'd4, 32'h0000_2003, 32'h0, 32'h80FF_0011, 1);
    check("lbu_const", bus.core_rd_o, 32'h0000_0080);
    do_txn(1'b0, 3'd1, 32'h0000_2002, 32'h0, 32'h80FF_0011, 0);
    check("lh_const", bus.core_rd_o, 32'hFFFF_80FF);
    bus.core_req_i = 1'b1;
    bus.core_we_i = 1'b1;
    bus.core_size_i = 3'd0;
    bus.core_addr_i = 32'h0000_3001;
    bus.core_wd_i = 32'h1234_56AB;
    step();
    check("sb_be", bus.mem_be_o, 4'b0010);
    check("sb_wd", bus.mem_wd_o, 32'hABAB_ABAB);
    check("sb_we", bus.mem_we_o, 1);
    bus.mem_ready_i = 1'b1;
    step();
    bus.mem_ready_i = 1'b0;
    step();
    bus.core_req_i = 1'b0;
    do_txn(1'b1, 3'd1, 32'h0000_3002, 32'h0000_BEEF, $urandom, 0);
    check("sh_rd_kept", bus.core_rd_o, 32'hFFFF_80FF);
    do_txn(1'b0, 3'd2, 32'h0000_4008, 32'h0, 32'h1357_9BDF, 5);
    bus.core_req_i = 1'b1;
    bus.core_we_i = 1'b0;
    bus.core_size_i = 3'd2;
    bus.core_addr_i = 32'h0000_5000;
    step();
    check("pre_rst_mem_req", bus.mem_req_o, 1);
    #2 rst = 1'b1;
    #1;
    exp_rd = '0;
    check("arst_mem_req", bus.mem_req_o, 0);
    check("arst_mem_be", bus.mem_be_o, 0);
    check("arst_rd", bus.core_rd_o, 0);
    check("arst_stall_idle", bus.core_stall_o, 1);
    #1 rst = 1'b0;
    do_txn(1'b0, 3'd5, 32'h0000_6002, 32'h0, 32'h8001_7FFE, 2);
    check("post_rst_rd", bus.core_rd_o, 32'h0000_8001);
    for (int t = 0; t < 40; t++) begin
      logic we = 1'($urandom);
      logic [2:0] sz = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      do_txn(we, sz, $urandom, $urandom, $urandom, int'($urandom_range(0, 3)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
